// File: rtl/sys_ctrl_tx_sched_if.sv
// Signal bundle between the TX scheduler, its RF/ALU sources, UART_TX and status consumers.
// master = scheduler side, slave = surrounding system.
interface sys_ctrl_tx_sched_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0]   RF_RD_DATA;
    logic                    RF_RD_VLD;
    logic [2*DATA_WIDTH-1:0] ALU_OUT;
    logic                    ALU_OUT_VLD;
    logic                    TX_BUSY;
    logic                    OVF_CLR;
    logic [DATA_WIDTH-1:0]   TX_P_DATA;
    logic                    TX_D_VLD;
    logic                    RF_OVF;
    logic                    ALU_OVF;
    logic                    SCHED_IDLE;

    modport master (
        input  RF_RD_DATA, RF_RD_VLD, ALU_OUT, ALU_OUT_VLD, TX_BUSY, OVF_CLR,
        output TX_P_DATA, TX_D_VLD, RF_OVF, ALU_OVF, SCHED_IDLE
    );

    modport slave (
        output RF_RD_DATA, RF_RD_VLD, ALU_OUT, ALU_OUT_VLD, TX_BUSY, OVF_CLR,
        input  TX_P_DATA, TX_D_VLD, RF_OVF, ALU_OVF, SCHED_IDLE
    );
endinterface

// File: rtl/sys_ctrl_tx_sched.sv
// Transmit-side scheduler: holds one RF byte and one 2-byte ALU result, arbitrates and streams
// them to UART_TX. Define TX_ROUND_ROBIN_EN for round-robin tie breaking (default: RF priority).
module sys_ctrl_tx_sched #(
    parameter int DATA_WIDTH  = 8,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                reset,
    sys_ctrl_tx_sched_if.master bus
);
    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_WAIT_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic                    rf_full_q, rf_full_d;
    logic [DATA_WIDTH-1:0]   rf_data_q, rf_data_d;
    logic                    alu_full_q, alu_full_d;
    logic [2*DATA_WIDTH-1:0] alu_data_q, alu_data_d;
    logic                    grant_alu_q, grant_alu_d;
    logic                    byte_hi_q, byte_hi_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_vld_q, tx_vld_d;
    logic                    rf_ovf_q, rf_ovf_d;
    logic                    alu_ovf_q, alu_ovf_d;
    logic                    tie_to_alu;
    logic                    pick_alu;
    logic                    rf_release, alu_release;
    logic                    rf_drop, alu_drop;

    // A slot frees up during the cycle its (last) byte is presented to UART_TX.
    assign rf_release  = tx_vld_q && !grant_alu_q;
    assign alu_release = tx_vld_q && grant_alu_q && byte_hi_q;
    assign rf_drop     = bus.RF_RD_VLD && rf_full_q && !rf_release;
    assign alu_drop    = bus.ALU_OUT_VLD && alu_full_q && !alu_release;

`ifdef TX_ROUND_ROBIN_EN
    logic last_alu_q, last_alu_d;
    assign tie_to_alu = !last_alu_q;
`else
    assign tie_to_alu = 1'b0;
`endif

    assign pick_alu = alu_full_q && (!rf_full_q || tie_to_alu);

    always_comb begin
        rf_full_d  = rf_full_q;
        rf_data_d  = rf_data_q;
        alu_full_d = alu_full_q;
        alu_data_d = alu_data_q;
        if (rf_release) begin
            rf_full_d = 1'b0;
        end
        if (bus.RF_RD_VLD && !rf_drop) begin
            rf_full_d = 1'b1;
            rf_data_d = bus.RF_RD_DATA;
        end
        if (alu_release) begin
            alu_full_d = 1'b0;
        end
        if (bus.ALU_OUT_VLD && !alu_drop) begin
            alu_full_d = 1'b1;
            alu_data_d = bus.ALU_OUT;
        end
        // Overflow set takes precedence over a simultaneous clear.
        rf_ovf_d  = rf_drop  ? 1'b1 : (bus.OVF_CLR ? 1'b0 : rf_ovf_q);
        alu_ovf_d = alu_drop ? 1'b1 : (bus.OVF_CLR ? 1'b0 : alu_ovf_q);
    end

    always_comb begin
        state_d     = state_q;
        grant_alu_d = grant_alu_q;
        byte_hi_d   = byte_hi_q;
        cnt_d       = cnt_q;
        tx_data_d   = tx_data_q;
        tx_vld_d    = 1'b0;
`ifdef TX_ROUND_ROBIN_EN
        last_alu_d  = last_alu_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if ((rf_full_q || alu_full_q) && !bus.TX_BUSY) begin
                    grant_alu_d = pick_alu;
                    byte_hi_d   = 1'b0;
`ifdef TX_ROUND_ROBIN_EN
                    last_alu_d  = pick_alu;
`endif
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (!grant_alu_q) begin
                    tx_data_d = rf_data_q;
                end else if (byte_hi_q) begin
                    tx_data_d = alu_data_q[2*DATA_WIDTH-1:DATA_WIDTH];
                end else begin
                    tx_data_d = alu_data_q[DATA_WIDTH-1:0];
                end
                tx_vld_d = 1'b1;
                cnt_d    = '0;
                state_d  = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                // No ack within the window: treat the frame as lost and move on.
                if (bus.TX_BUSY || (cnt_q == CNT_W'(ACK_TIMEOUT - 1))) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.TX_BUSY) begin
                    if (grant_alu_q && !byte_hi_q) begin
                        byte_hi_d = 1'b1;
                        state_d   = ST_ISSUE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rf_full_q   <= 1'b0;
            rf_data_q   <= '0;
            alu_full_q  <= 1'b0;
            alu_data_q  <= '0;
            grant_alu_q <= 1'b0;
            byte_hi_q   <= 1'b0;
            cnt_q       <= '0;
            tx_data_q   <= '0;
            tx_vld_q    <= 1'b0;
            rf_ovf_q    <= 1'b0;
            alu_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rf_full_q   <= rf_full_d;
            rf_data_q   <= rf_data_d;
            alu_full_q  <= alu_full_d;
            alu_data_q  <= alu_data_d;
            grant_alu_q <= grant_alu_d;
            byte_hi_q   <= byte_hi_d;
            cnt_q       <= cnt_d;
            tx_data_q   <= tx_data_d;
            tx_vld_q    <= tx_vld_d;
            rf_ovf_q    <= rf_ovf_d;
            alu_ovf_q   <= alu_ovf_d;
        end
    end

`ifdef TX_ROUND_ROBIN_EN
    // Resets to ALU so that RF wins the first tie.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_alu_q <= 1'b1;
        end else begin
            last_alu_q <= last_alu_d;
        end
    end
`endif

    assign bus.TX_P_DATA  = tx_data_q;
    assign bus.TX_D_VLD   = tx_vld_q;
    assign bus.RF_OVF     = rf_ovf_q;
    assign bus.ALU_OVF    = alu_ovf_q;
    assign bus.SCHED_IDLE = (state_q == ST_IDLE) && !rf_full_q && !alu_full_q;
endmodule
